cipher_datapath: RTL and testbench
==================================

// Module: cipher_datapath
// PURPOSE
//  Responder end of the controller->datapath control interface. It consumes the 3-bit state code
//  broadcast by the cipher controller each cycle, and from it:
//  - latches two input bytes,
//  - derives a round key in two steps,
//  - then encodes or decodes the payload byte.
//  The decode operation is the exact inverse of encode under the same key. Sequence violations are flagged.
// PARAMETERS
//  WIDTH     8      datapath/byte width
//  KEY_SEED  8'hA5  XOR constant applied in KEY_GEN_1
//  KEY_MIX   8'h3C  XOR constant applied in KEY_GEN_2
//  ROT       3      payload rotate amount, 1..WIDTH-1
// PORTS
//  clka       in   1      single clock; all state updates on negedge clka
//  restart    in   1      synchronous, active-high reset
//  state_in   in   3      controller state code: IDLE=000 KG1=001 KG2=010 ENC=011 DEC=100 LB1=101 LB2=110
//  data_in    in   WIDTH  byte bus; sampled in LB1 (key byte) and LB2 (payload byte)
//  data_out   out  WIDTH  result byte, held until the next result
//  out_valid  out  1      one-cycle pulse, data_out is new
//  out_mode   out  1      1 = data_out was encoded, 0 = decoded
//  busy       out  1      high from the LB1 cycle until the cycle out_valid pulses
//  seq_err    out  1      sticky protocol-violation flag
// BEHAVIOUR
//  Reset: on restart=1 at a clka edge, all outputs and internal regs clear to 0 and the tracker goes to T_IDLE.
//   - Applies mid-operation, with no partial result emitted.
//  Tracker FSM, advancing one step per cycle:
//   - T_IDLE -LB1-> T_B1 -LB2-> T_B2 -KG1-> T_K1 -KG2-> T_K2 -ENC|DEC-> T_IDLE.
//   - In T_IDLE only IDLE or LB1 are legal; IDLE may repeat any number of cycles.
//   - Every non-IDLE code lasts exactly one cycle.
//  Any other code, including 111 or a repeated non-IDLE code, sets seq_err=1 and sends the tracker to T_ERR:
//   - T_ERR ignores all codes; busy=0 and out_valid=0.
//   - The only exit from T_ERR is restart.
//  Datapath actions, registered at the edge on which the code is sampled:
//   - LB1: b1 <= data_in.
//   - LB2: b2 <= data_in.
//   - KG1: k <= b1 ^ KEY_SEED.
//   - KG2: k <= rotl(k,1) ^ KEY_MIX.
//   - ENC: data_out <= rotl(b2 ^ k, ROT); out_mode <= 1.
//   - DEC: data_out <= rotr(b2, ROT) ^ k; out_mode <= 0.
//  out_valid=1 in the cycle after the ENC/DEC edge, and only for that single cycle.
//   - Latency from the LB1 sample to out_valid is 5 cycles.
//  All arithmetic is modulo 2^WIDTH, and rotates wrap within WIDTH bits. There are no carries.
//  A new LB1 may follow ENC/DEC immediately (back-to-back transactions).
//   - In that case out_valid of the previous transaction coincides with busy=1 of the new one.
//  If restart and an error code arrive in the same cycle, restart wins.
//  Registers are only written by their own codes; b1, b2 and k are otherwise held.
// STRUCTURE
//  cipher_pkg, shared with the controller, holds:
//   - the state-code localparams,
//   - the tracker enum,
//   - rotl/rotr functions parameterised by WIDTH.
//  Sub-module cipher_seq_checker contains the tracker FSM. It outputs a one-hot step strobe plus seq_err.
//  The top level holds the b1/b2/k/data_out registers.
// TESTING (WIDTH=8, default params)
//  1. Encode. IDLE, LB1 with data_in=12, LB2 with 5A, KG1, KG2, ENC.
//     -> k=B7 then 53; data_out=48, out_mode=1, out_valid for 1 cycle, 5 cycles after LB1.
//  2. Decode. Same sequence with LB2=48 and DEC. -> data_out=5A, out_mode=0 (round-trip of test 1).
//  3. Back-to-back. Encode transaction, then LB1 immediately after ENC.
//     -> out_valid and busy both 1 in that cycle; second result correct.
//  4. Protocol errors. LB1, LB2, then ENC (skipping KG1/KG2); separately LB1,LB1; separately code 111.
//     -> seq_err=1 on the next cycle, no out_valid, subsequent codes ignored until restart.
//  5. Reset mid-operation. restart during the KG1 cycle.
//     -> all outputs 0, no out_valid; a fresh sequence then produces the correct result.
//  6. Idle hold. IDLE for 20 cycles -> busy=0, out_valid=0, data_out holds the last result.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher controller/datapath pair: state codes,
// datapath tracker states, step strobes and width-generic rotate helpers.
package cipher_pkg;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_KG1  = 3'b001;
   localparam logic [2:0] ST_KG2  = 3'b010;
   localparam logic [2:0] ST_ENC  = 3'b011;
   localparam logic [2:0] ST_DEC  = 3'b100;
   localparam logic [2:0] ST_LB1  = 3'b101;
   localparam logic [2:0] ST_LB2  = 3'b110;

   localparam int unsigned ROT_MAX_W = 32;

   typedef enum logic [2:0] {
      T_IDLE = 3'd0,
      T_B1   = 3'd1,
      T_B2   = 3'd2,
      T_K1   = 3'd3,
      T_K2   = 3'd4,
      T_ERR  = 3'd5
   } trk_t;

   typedef struct packed {
      logic lb1;
      logic lb2;
      logic kg1;
      logic kg2;
      logic enc;
      logic dec;
   } step_t;

   function automatic logic [ROT_MAX_W-1:0] rot_mask(input int unsigned w);
      return (w >= ROT_MAX_W) ? {ROT_MAX_W{1'b1}} : ((32'd1 << w) - 32'd1);
   endfunction

   // Rotates act on the low w bits of a zero-extended operand.
   function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] v,
                                                 input int unsigned w,
                                                 input int unsigned n);
      int unsigned s;
      s = n % w;
      return ((v << s) | (v >> (w - s))) & rot_mask(w);
   endfunction

   function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] v,
                                                 input int unsigned w,
                                                 input int unsigned n);
      int unsigned s;
      s = n % w;
      return ((v >> s) | (v << (w - s))) & rot_mask(w);
   endfunction

endpackage

// File: rtl/cipher_seq_checker.sv
// Tracks the controller's state-code sequence, issuing one-hot step strobes
// for legal codes and a sticky error flag for any out-of-order code.
module cipher_seq_checker
   import cipher_pkg::*;
(
   input  logic       clka,
   input  logic       restart,
   input  logic [2:0] state_in,
   output step_t      step,
   output trk_t       trk,
   output logic       seq_err
);

   trk_t trk_nxt_s;
   logic bad_s;

   // Next tracker state and step decode; restart suppresses all strobes.
   always_comb begin
      trk_nxt_s = trk;
      step      = step_t'(6'b000000);
      bad_s     = 1'b0;
      if (restart) begin
         trk_nxt_s = T_IDLE;
      end else begin
         case (trk)
            T_IDLE: begin
               if (state_in == ST_LB1) begin
                  step.lb1  = 1'b1;
                  trk_nxt_s = T_B1;
               end else if (state_in == ST_IDLE) begin
                  trk_nxt_s = T_IDLE;
               end else begin
                  bad_s = 1'b1;
               end
            end
            T_B1: begin
               if (state_in == ST_LB2) begin
                  step.lb2  = 1'b1;
                  trk_nxt_s = T_B2;
               end else begin
                  bad_s = 1'b1;
               end
            end
            T_B2: begin
               if (state_in == ST_KG1) begin
                  step.kg1  = 1'b1;
                  trk_nxt_s = T_K1;
               end else begin
                  bad_s = 1'b1;
               end
            end
            T_K1: begin
               if (state_in == ST_KG2) begin
                  step.kg2  = 1'b1;
                  trk_nxt_s = T_K2;
               end else begin
                  bad_s = 1'b1;
               end
            end
            T_K2: begin
               if (state_in == ST_ENC) begin
                  step.enc  = 1'b1;
                  trk_nxt_s = T_IDLE;
               end else if (state_in == ST_DEC) begin
                  step.dec  = 1'b1;
                  trk_nxt_s = T_IDLE;
               end else begin
                  bad_s = 1'b1;
               end
            end
            T_ERR: begin
               trk_nxt_s = T_ERR;
            end
            default: begin
               bad_s = 1'b1;
            end
         endcase
         if (bad_s) begin
            trk_nxt_s = T_ERR;
         end else begin
            trk_nxt_s = trk_nxt_s;
         end
      end
   end

   // Tracker state and sticky error flag; only restart leaves T_ERR.
   always_ff @(negedge clka) begin
      if (restart) begin
         trk     <= T_IDLE;
         seq_err <= 1'b0;
      end else begin
         trk     <= trk_nxt_s;
         seq_err <= seq_err | bad_s;
      end
   end

endmodule

// File: rtl/cipher_datapath.sv
// Datapath responder: latches key/payload bytes, derives the round key in two
// steps and encodes or decodes the payload under control of the state codes.
module cipher_datapath
   import cipher_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] KEY_SEED = 8'hA5,
   parameter logic [WIDTH-1:0] KEY_MIX  = 8'h3C,
   parameter int unsigned      ROT      = 3
) (
   input  logic             clka,
   input  logic             restart,
   input  logic [2:0]       state_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             out_mode,
   output logic             busy,
   output logic             seq_err
);

   step_t            step;
   trk_t             trk;
   logic [WIDTH-1:0] b1_r, b2_r, k_r;
   logic [WIDTH-1:0] kg1_s, kg2_s, enc_s, dec_s;

   cipher_seq_checker u_seq (
      .clka     (clka),
      .restart  (restart),
      .state_in (state_in),
      .step     (step),
      .trk      (trk),
      .seq_err  (seq_err)
   );

   // Candidate key and result values for the strobes below.
   always_comb begin
      kg1_s = b1_r ^ KEY_SEED;
      kg2_s = WIDTH'(rotl(ROT_MAX_W'(k_r), WIDTH, 32'd1)) ^ KEY_MIX;
      enc_s = WIDTH'(rotl(ROT_MAX_W'(b2_r ^ k_r), WIDTH, ROT));
      dec_s = WIDTH'(rotr(ROT_MAX_W'(b2_r), WIDTH, ROT)) ^ k_r;
   end

   // Busy covers the LB1 cycle itself through the result pulse.
   always_comb begin
      busy = out_valid | step.lb1 |
             (trk inside {T_B1, T_B2, T_K1, T_K2});
   end

   // Datapath registers; each one changes only on its own step strobe.
   always_ff @(negedge clka) begin
      if (restart) begin
         b1_r      <= {WIDTH{1'b0}};
         b2_r      <= {WIDTH{1'b0}};
         k_r       <= {WIDTH{1'b0}};
         data_out  <= {WIDTH{1'b0}};
         out_mode  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= step.enc | step.dec;
         if (step.lb1) begin
            b1_r <= data_in;
         end else begin
            b1_r <= b1_r;
         end
         if (step.lb2) begin
            b2_r <= data_in;
         end else begin
            b2_r <= b2_r;
         end
         if (step.kg1) begin
            k_r <= kg1_s;
         end else if (step.kg2) begin
            k_r <= kg2_s;
         end else begin
            k_r <= k_r;
         end
         if (step.enc) begin
            data_out <= enc_s;
            out_mode <= 1'b1;
         end else if (step.dec) begin
            data_out <= dec_s;
            out_mode <= 1'b0;
         end else begin
            data_out <= data_out;
            out_mode <= out_mode;
         end
      end
   end

endmodule

// File: tb/tb_cipher_datapath.sv
// Scoreboard bench for cipher_datapath: a reference model predicts results,
// key, busy and error flags; results are queued and popped on out_valid.
module tb_cipher_datapath;

   localparam logic [2:0] C_IDLE = 3'b000;
   localparam logic [2:0] C_KG1  = 3'b001;
   localparam logic [2:0] C_KG2  = 3'b010;
   localparam logic [2:0] C_ENC  = 3'b011;
   localparam logic [2:0] C_DEC  = 3'b100;
   localparam logic [2:0] C_LB1  = 3'b101;
   localparam logic [2:0] C_LB2  = 3'b110;
   localparam logic [2:0] C_BAD  = 3'b111;

   logic       clka = 1'b1;
   logic       restart = 1'b1;
   logic [2:0] state_in = C_IDLE;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       out_valid, out_mode, busy, seq_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [7:0] d;
      logic       m;
      int         lb1;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   int         m_pos = 0;      // -1 = error, 0 = idle, 1..4 = bytes/key steps done
   logic       m_err = 1'b0;
   logic       m_pulse = 1'b0;
   logic [7:0] m_b1 = 8'h00, m_b2 = 8'h00, m_k = 8'h00;
   logic [7:0] m_dout = 8'h00;
   logic       m_mode = 1'b0;
   int         m_lb1 = 0;

   cipher_datapath dut (
      .clka      (clka),
      .restart   (restart),
      .state_in  (state_in),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_mode  (out_mode),
      .busy      (busy),
      .seq_err   (seq_err)
   );

   always #5 clka = ~clka;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] rl3(input logic [7:0] x);
      return {x[4:0], x[7:5]};
   endfunction

   function automatic logic [7:0] rr3(input logic [7:0] x);
      return {x[2:0], x[7:3]};
   endfunction

   // Drive one cycle's inputs, let the sampling edge pass, advance the model.
   task automatic drive(input logic [2:0] code, input logic [7:0] d, input logic rst);
      logic [2:0] legal;
      state_in = code;
      data_in  = d;
      restart  = rst;
      @(negedge clka);
      cyc++;
      m_pulse = 1'b0;
      if (rst) begin
         m_pos = 0; m_err = 1'b0;
         m_b1 = 8'h00; m_b2 = 8'h00; m_k = 8'h00;
         m_dout = 8'h00; m_mode = 1'b0;
         sb.delete();
      end else if (m_pos >= 0) begin
         legal = (m_pos == 0) ? C_LB1 : (m_pos == 1) ? C_LB2 :
                 (m_pos == 2) ? C_KG1 : C_KG2;
         if (m_pos == 0 && code == C_IDLE) begin
            m_pos = 0;
         end else if (m_pos < 4 && code == legal) begin
            if (m_pos == 0) begin m_b1 = d; m_lb1 = cyc; end
            if (m_pos == 1) m_b2 = d;
            if (m_pos == 2) m_k = m_b1 ^ 8'hA5;
            if (m_pos == 3) m_k = {m_k[6:0], m_k[7]} ^ 8'h3C;
            m_pos++;
         end else if (m_pos == 4 && (code == C_ENC || code == C_DEC)) begin
            if (code == C_ENC) sb.push_back('{rl3(m_b2 ^ m_k), 1'b1, m_lb1});
            else               sb.push_back('{rr3(m_b2) ^ m_k, 1'b0, m_lb1});
            m_pulse = 1'b1;
            m_pos = 0;
         end else begin
            m_err = 1'b1;
            m_pos = -1;
         end
      end
      #1;
   endtask

   task automatic txn(input logic [7:0] b1, input logic [7:0] b2, input logic enc);
      drive(C_LB1, b1, 1'b0);
      drive(C_LB2, b2, 1'b0);
      drive(C_KG1, 8'h00, 1'b0);
      drive(C_KG2, 8'h00, 1'b0);
      drive(enc ? C_ENC : C_DEC, 8'h00, 1'b0);
   endtask

   // Mid-cycle monitor: pops the scoreboard on out_valid and checks all outputs.
   initial begin
      forever begin
         @(posedge clka);
         check("out_valid", out_valid, m_pulse);
         if (m_pulse) begin
            check("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               m_dout = e.d;
               m_mode = e.m;
               check("latency", cyc + 1 - e.lb1, 5);
            end
         end
         check("data_out", data_out, m_dout);
         check("out_mode", out_mode, m_mode);
         check("seq_err", seq_err, m_err);
         check("busy", busy, m_pulse || (m_pos >= 1 && m_pos <= 4) ||
                             (m_pos == 0 && state_in == C_LB1 && !restart));
         check("key", dut.k_r, m_k);
      end
   end

   initial begin
      drive(C_IDLE, 8'h00, 1'b1);
      drive(C_IDLE, 8'h00, 1'b1);
      check("rst_dout", data_out, 8'h00);
      check("rst_valid", out_valid, 1'b0);

      // Encode reference vector
      drive(C_IDLE, 8'h00, 1'b0);
      drive(C_LB1, 8'h12, 1'b0);
      drive(C_LB2, 8'h5A, 1'b0);
      drive(C_KG1, 8'h00, 1'b0);
      check("k_gen1", dut.k_r, 8'hB7);
      drive(C_KG2, 8'h00, 1'b0);
      check("k_gen2", dut.k_r, 8'h53);
      drive(C_ENC, 8'h00, 1'b0);
      check("enc_dout", data_out, 8'h48);
      check("enc_mode", out_mode, 1'b1);
      drive(C_IDLE, 8'h00, 1'b0);

      // Decode is the inverse
      txn(8'h12, 8'h48, 1'b0);
      check("dec_dout", data_out, 8'h5A);
      check("dec_mode", out_mode, 1'b0);
      drive(C_IDLE, 8'h00, 1'b0);

      // Back-to-back transactions
      txn(8'h34, 8'hA7, 1'b1);
      txn(8'hC3, 8'h0F, 1'b0);
      txn(8'hFF, 8'h00, 1'b1);
      drive(C_IDLE, 8'h00, 1'b0);

      // Skipped key steps, then further codes must be ignored
      drive(C_LB1, 8'h11, 1'b0);
      drive(C_LB2, 8'h22, 1'b0);
      drive(C_ENC, 8'h00, 1'b0);
      check("err_skip", seq_err, 1'b1);
      txn(8'h01, 8'h02, 1'b1);
      drive(C_IDLE, 8'h00, 1'b0);
      check("err_sticky", seq_err, 1'b1);
      drive(C_IDLE, 8'h00, 1'b1);

      drive(C_LB1, 8'h11, 1'b0);
      drive(C_LB1, 8'h22, 1'b0);
      check("err_repeat", seq_err, 1'b1);
      drive(C_IDLE, 8'h00, 1'b1);

      drive(C_IDLE, 8'h00, 1'b0);
      drive(C_BAD, 8'h00, 1'b0);
      check("err_111", seq_err, 1'b1);
      drive(C_IDLE, 8'h00, 1'b1);

      drive(C_BAD, 8'h00, 1'b1);
      check("rst_wins", seq_err, 1'b0);
      drive(C_IDLE, 8'h00, 1'b0);

      // Restart in the KG1 cycle, then a clean transaction
      drive(C_LB1, 8'h12, 1'b0);
      drive(C_LB2, 8'h5A, 1'b0);
      drive(C_KG1, 8'h00, 1'b1);
      check("midrst_key", dut.k_r, 8'h00);
      txn(8'h12, 8'h5A, 1'b1);
      check("midrst_dout", data_out, 8'h48);

      // Idle hold
      for (int i = 0; i < 20; i++) drive(C_IDLE, 8'h00, 1'b0);
      check("idle_hold", data_out, 8'h48);

      // Random round-trips with random idle gaps
      for (int i = 0; i < 8; i++) begin
         txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) drive(C_IDLE, 8'h00, 1'b0);
      end
      drive(C_IDLE, 8'h00, 1'b0);
      drive(C_IDLE, 8'h00, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
